tcam_key_unpacker: RTL and testbench

- Inverse of the 128-bit TCAM key packer: takes packed lookup keys back apart into their metadata fields.
- Sources are the TCAM entry readback path and the debug/mirror key stream.
- Registered valid/ready pipeline with a skid buffer, so full throughput is held under backpressure.
- Checks each key for format violations, optionally drops violating keys, and keeps saturating accept and error counters for the control plane.

---
 rtl/tcam_key_unpacker_if.sv | 36 +++
 rtl/tcam_key_unpacker.sv | 134 +++++++++++++
 tb/tb_tcam_key_unpacker.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_key_unpacker_if.sv
// Handshake and field bus of the TCAM key unpacker: packed key in, unpacked
// fields out, each side with its own valid/ready pair.
interface tcam_key_unpacker_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;

  logic         out_valid;
  logic         out_ready;
  logic [31:0]  src_ip;
  logic [31:0]  dst_ip;
  logic [7:0]   ip_proto;
  logic [15:0]  src_port;
  logic [15:0]  dst_port;
  logic [11:0]  vlan_id;
  logic [5:0]   dscp;
  logic         is_ipv4;
  logic         is_ipv6;
  logic         is_arp;
  logic         is_fragmented;
  logic [2:0]   err_flags;

  // Key producer and field consumer side
  modport master (
    output key_valid, key_in, out_ready,
    input  key_ready, out_valid, src_ip, dst_ip, ip_proto, src_port, dst_port,
           vlan_id, dscp, is_ipv4, is_ipv6, is_arp, is_fragmented, err_flags
  );

  // Unpacker side
  modport slave (
    input  key_valid, key_in, out_ready,
    output key_ready, out_valid, src_ip, dst_ip, ip_proto, src_port, dst_port,
           vlan_id, dscp, is_ipv4, is_ipv6, is_arp, is_fragmented, err_flags
  );
endinterface

// File: rtl/tcam_key_unpacker.sv
// TCAM key unpacker: splits 128-bit packed lookup keys into metadata fields,
// flags format violations, optionally drops bad keys, and keeps saturating
// accept/error counters. Output register O plus skid register S give full
// throughput with a registered key_ready.
module tcam_key_unpacker #(
  parameter bit          DROP_ERR = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tcam_key_unpacker_if.slave   kif,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     key_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  logic [2:0]   in_err;
  logic         accept;
  logic         keep;
  logic         drain;

  logic         o_vld_q, o_vld_d;
  logic [127:2] o_key_q, o_key_d;
  logic [2:0]   o_err_q, o_err_d;
  logic         s_vld_q, s_vld_d;
  logic [127:2] s_key_q, s_key_d;
  logic [2:0]   s_err_q, s_err_d;
  logic         key_ready_q, key_ready_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Format checks on the incoming key: reserved bits, class exclusivity, ARP with L4 content
  always_comb begin
    in_err    = '0;
    in_err[0] = |kif.key_in[1:0];
    in_err[1] = (kif.key_in[5] & kif.key_in[4]) |
                (kif.key_in[5] & kif.key_in[3]) |
                (kif.key_in[4] & kif.key_in[3]);
    in_err[2] = kif.key_in[3] & ((|kif.key_in[63:24]) | kif.key_in[2]);
  end

  assign accept = kif.key_valid && key_ready_q;
  assign keep   = accept && !(DROP_ERR && (in_err != 3'b000));
  assign drain  = o_vld_q && kif.out_ready;

  // Output/skid register steering; S always drains into O before new keys so order is kept
  always_comb begin
    o_vld_d = o_vld_q;
    o_key_d = o_key_q;
    o_err_d = o_err_q;
    s_vld_d = s_vld_q;
    s_key_d = s_key_q;
    s_err_d = s_err_q;
    if (!o_vld_q || drain) begin
      if (s_vld_q) begin
        o_vld_d = 1'b1;
        o_key_d = s_key_q;
        o_err_d = s_err_q;
        s_vld_d = keep;
        if (keep) begin
          s_key_d = kif.key_in[127:2];
          s_err_d = in_err;
        end
      end else if (keep) begin
        o_vld_d = 1'b1;
        o_key_d = kif.key_in[127:2];
        o_err_d = in_err;
      end else begin
        o_vld_d = 1'b0;
      end
    end else if (keep) begin
      s_vld_d = 1'b1;
      s_key_d = kif.key_in[127:2];
      s_err_d = in_err;
    end
    key_ready_d = !s_vld_d;
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    key_cnt_d = key_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      key_cnt_d = '0;
      err_cnt_d = '0;
    end else if (accept) begin
      if (key_cnt_q != '1) key_cnt_d = key_cnt_q + 1'b1;
      if ((in_err != 3'b000) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q     <= 1'b0;
      o_key_q     <= '0;
      o_err_q     <= '0;
      s_vld_q     <= 1'b0;
      s_key_q     <= '0;
      s_err_q     <= '0;
      key_ready_q <= 1'b1;
      key_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      o_vld_q     <= o_vld_d;
      o_key_q     <= o_key_d;
      o_err_q     <= o_err_d;
      s_vld_q     <= s_vld_d;
      s_key_q     <= s_key_d;
      s_err_q     <= s_err_d;
      key_ready_q <= key_ready_d;
      key_cnt_q   <= key_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign kif.key_ready     = key_ready_q;
  assign kif.out_valid     = o_vld_q;
  assign kif.src_ip        = o_key_q[127:96];
  assign kif.dst_ip        = o_key_q[95:64];
  assign kif.ip_proto      = o_key_q[63:56];
  assign kif.src_port      = o_key_q[55:40];
  assign kif.dst_port      = o_key_q[39:24];
  assign kif.vlan_id       = o_key_q[23:12];
  assign kif.dscp          = o_key_q[11:6];
  assign kif.is_ipv4       = o_key_q[5];
  assign kif.is_ipv6       = o_key_q[4];
  assign kif.is_arp        = o_key_q[3];
  assign kif.is_fragmented = o_key_q[2];
  assign kif.err_flags     = o_err_q;
  assign key_cnt           = key_cnt_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_tcam_key_unpacker.sv
// Bench for tcam_key_unpacker: two instances (errors presented / errors
// dropped with 4-bit counters) fed the same key stream; expected fields and
// counters come from field-level reference values, checked by monitors.
module tb_tcam_key_unpacker;

  typedef struct {
    logic [31:0] sip, dip;
    logic [7:0]  proto;
    logic [15:0] sp, dp;
    logic [11:0] vlan;
    logic [5:0]  dscp;
    logic        v4, v6, arp, frag;
    logic [1:0]  rsvd;
  } fld_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_clr = 1'b0;
  logic         kv = 1'b0;
  logic [127:0] kin = '0;
  logic [2:0]   kerr = '0;
  logic         ordy = 1'b0;
  logic [15:0]  kc0, ec0;
  logic [3:0]   kc1, ec1;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned n_out1 = 0;
  int unsigned mk0 = 0, me0 = 0, mk1 = 0, me1 = 0;
  logic [128:0] q0[$];
  logic [128:0] q1[$];

  always #5 clk = ~clk;

  tcam_key_unpacker_if if0 ();
  tcam_key_unpacker_if if1 ();

  assign if0.key_valid = kv;
  assign if0.key_in    = kin;
  assign if0.out_ready = ordy;
  assign if1.key_valid = kv;
  assign if1.key_in    = kin;
  assign if1.out_ready = ordy;

  tcam_key_unpacker #(.DROP_ERR(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .kif(if0.slave),
    .cnt_clr(cnt_clr), .key_cnt(kc0), .err_cnt(ec0)
  );

  tcam_key_unpacker #(.DROP_ERR(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .kif(if1.slave),
    .cnt_clr(cnt_clr), .key_cnt(kc1), .err_cnt(ec1)
  );

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  function automatic logic [127:0] pack(input fld_t f);
    return {f.sip, f.dip, f.proto, f.sp, f.dp, f.vlan, f.dscp,
            f.v4, f.v6, f.arp, f.frag, f.rsvd};
  endfunction

  function automatic logic [2:0] ref_err(input fld_t f);
    logic [2:0] e;
    int n_cls;
    n_cls = int'(f.v4) + int'(f.v6) + int'(f.arp);
    e[0] = (f.rsvd != 2'b00);
    e[1] = (n_cls > 1);
    e[2] = f.arp && (f.proto != 0 || f.sp != 0 || f.dp != 0 || f.frag);
    return e;
  endfunction

  function automatic logic [128:0] ref_out(input fld_t f, input logic [2:0] e);
    return {f.sip, f.dip, f.proto, f.sp, f.dp, f.vlan, f.dscp,
            f.v4, f.v6, f.arp, f.frag, e};
  endfunction

  function automatic fld_t zero_fld(input logic [31:0] id);
    fld_t f;
    f = '{sip: id, dip: 32'h0, proto: 8'h0, sp: 16'h0, dp: 16'h0, vlan: 12'h0,
          dscp: 6'h0, v4: 1'b1, v6: 1'b0, arp: 1'b0, frag: 1'b0, rsvd: 2'b00};
    return f;
  endfunction

  function automatic fld_t rnd_fld();
    fld_t f;
    int c;
    f.sip = $urandom; f.dip = $urandom;
    f.proto = 8'($urandom); f.sp = 16'($urandom); f.dp = 16'($urandom);
    f.vlan = 12'($urandom); f.dscp = 6'($urandom); f.frag = 1'($urandom);
    c = $urandom_range(0, 9);
    f.v4 = (c <= 3) || (c == 8); f.v6 = (c == 4) || (c == 5);
    f.arp = (c == 6) || (c == 7) || (c == 8) || (c == 9);
    if (f.arp && $urandom_range(0, 3) != 0) begin
      f.proto = 0; f.sp = 0; f.dp = 0; f.frag = 0;
    end
    f.rsvd = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return f;
  endfunction

  // Offer one key once both instances are ready; it is accepted at the next edge
  task automatic send(input fld_t f, input logic clr);
    int n;
    logic [2:0] e;
    n = 0;
    while (!(if0.key_ready && if1.key_ready)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        fail("ready_timeout");
        return;
      end
    end
    e = ref_err(f);
    kv = 1'b1; kin = pack(f); kerr = e; cnt_clr = clr;
    q0.push_back(ref_out(f, e));
    if (e == 3'b000) q1.push_back(ref_out(f, 3'b000));
    @(posedge clk); #1;
    kv = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic clr_pulse();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    ordy = 1'b1;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        fail("drain_timeout");
        q0.delete(); q1.delete();
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  // Reference counters, updated at the edge where a key is accepted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk0 <= 0; me0 <= 0; mk1 <= 0; me1 <= 0;
    end else if (cnt_clr) begin
      mk0 <= 0; me0 <= 0; mk1 <= 0; me1 <= 0;
    end else if (kv) begin
      mk0 <= (mk0 == 65535) ? mk0 : mk0 + 1;
      mk1 <= (mk1 == 15) ? mk1 : mk1 + 1;
      if (kerr != 3'b000) begin
        me0 <= (me0 == 65535) ? me0 : me0 + 1;
        me1 <= (me1 == 15) ? me1 : me1 + 1;
      end
    end
  end

  initial begin : mon0
    logic [128:0] act;
    bit stall;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 0;
      else begin
        act = {if0.src_ip, if0.dst_ip, if0.ip_proto, if0.src_port, if0.dst_port,
               if0.vlan_id, if0.dscp, if0.is_ipv4, if0.is_ipv6, if0.is_arp,
               if0.is_fragmented, if0.err_flags};
        if (stall && !if0.out_valid) chk("hold_valid0", 129'(if0.out_valid), 129'd1);
        if (if0.out_valid) begin
          if (q0.size() == 0) fail("spurious_out0");
          else begin
            chk("fields0", act, q0[0]);
            if (ordy) void'(q0.pop_front());
          end
        end
        stall = if0.out_valid && !ordy;
      end
    end
  end

  initial begin : mon1
    logic [128:0] act;
    bit stall;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 0;
      else begin
        act = {if1.src_ip, if1.dst_ip, if1.ip_proto, if1.src_port, if1.dst_port,
               if1.vlan_id, if1.dscp, if1.is_ipv4, if1.is_ipv6, if1.is_arp,
               if1.is_fragmented, if1.err_flags};
        if (stall && !if1.out_valid) chk("hold_valid1", 129'(if1.out_valid), 129'd1);
        if (if1.out_valid) begin
          if (q1.size() == 0) fail("spurious_out1");
          else begin
            chk("fields1", act, q1[0]);
            if (ordy) begin
              void'(q1.pop_front());
              n_out1++;
            end
          end
        end
        stall = if1.out_valid && !ordy;
      end
    end
  end

  initial begin : mon_cnt
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("key_cnt0", 129'(kc0), 129'(mk0));
        chk("err_cnt0", 129'(ec0), 129'(me0));
        chk("key_cnt1", 129'(kc1), 129'(mk1));
        chk("err_cnt1", 129'(ec1), 129'(me1));
      end
    end
  end

  initial begin : stim
    fld_t f;
    int unsigned n_before;
    bit rnd_done;

    // Reset state
    #12;
    chk("rst_ovalid", 129'(if0.out_valid), 129'd0);
    chk("rst_kready", 129'(if0.key_ready), 129'd1);
    chk("rst_fields", 129'({if0.src_ip, if0.dst_port, if0.err_flags}), 129'd0);
    chk("rst_cnt", 129'({kc0, ec0}), 129'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single key, one-cycle latency
    ordy = 1'b1;
    f = '{sip: 32'hC0A80001, dip: 32'h0A000002, proto: 8'h06, sp: 16'h1F90,
          dp: 16'h0050, vlan: 12'h064, dscp: 6'h2E, v4: 1'b1, v6: 1'b0,
          arp: 1'b0, frag: 1'b0, rsvd: 2'b00};
    send(f, 1'b0);
    chk("t1_latency", 129'(if0.out_valid), 129'd1);
    chk("t1_src_ip", 129'(if0.src_ip), 129'h0C0A80001);
    chk("t1_cnt", 129'({kc0, ec0}), 129'({16'd1, 16'd0}));
    wait_drain();

    // 2: backpressure fills O then S
    ordy = 1'b0;
    send(zero_fld(1), 1'b0);
    send(zero_fld(2), 1'b0);
    chk("t2_kready_low", 129'(if0.key_ready), 129'd0);
    fork
      begin
        send(zero_fld(3), 1'b0);
        send(zero_fld(4), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ordy = 1'b1;
      end
    join
    wait_drain();

    // 3: error flags presented with the fields
    clr_pulse();
    f = zero_fld(5); f.rsvd = 2'b01; f.arp = 1'b1;
    send(f, 1'b0);
    f = zero_fld(6); f.v4 = 1'b0; f.arp = 1'b1; f.dp = 16'h0050;
    send(f, 1'b0);
    chk("t3_err_cnt", 129'(ec0), 129'd2);
    wait_drain();

    // 4: good, bad, good back-to-back; dropping instance emits only the good ones
    clr_pulse();
    n_before = n_out1;
    send(zero_fld(7), 1'b0);
    f = zero_fld(8); f.rsvd = 2'b10;
    send(f, 1'b0);
    send(zero_fld(9), 1'b0);
    wait_drain();
    chk("t4_outputs", 129'(n_out1 - n_before), 129'd2);
    chk("t4_cnt1", 129'({kc1, ec1}), 129'({4'd3, 4'd1}));

    // 5: saturation of the 4-bit counters, then clear alongside an accept
    clr_pulse();
    for (int i = 0; i < 17; i++) send(zero_fld(32'(100 + i)), 1'b0);
    chk("t5_sat", 129'(kc1), 129'd15);
    chk("t5_nosat", 129'(kc0), 129'd17);
    send(zero_fld(200), 1'b1);
    chk("t5_clr1", 129'(kc1), 129'd0);
    chk("t5_clr0", 129'(kc0), 129'd0);
    wait_drain();

    // 6: asynchronous reset with O and S full
    ordy = 1'b0;
    send(zero_fld(300), 1'b0);
    send(zero_fld(301), 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ovalid0", 129'(if0.out_valid), 129'd0);
    chk("t6_ovalid1", 129'(if1.out_valid), 129'd0);
    q0.delete(); q1.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_kready", 129'(if0.key_ready), 129'd1);
    chk("t6_cnt", 129'({kc0, ec0, kc1, ec1}), 129'd0);
    ordy = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Random traffic with random backpressure and occasional clears
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(rnd_fld(), ($urandom_range(0, 49) == 0));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ordy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
